// File: rtl/roe_sequencer_pkg.sv
// roe_sequencer_pkg: shared sequencer states, opcode enum and HARD sub-op constants
package roe_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        ERR
    } seq_state_t;

    typedef enum logic [2:0] {
        OP_REG,
        OP_ARITH,
        OP_SHIFT,
        OP_HARD,
        OP_SLT,
        OP_XOR,
        OP_AND,
        OP_OR
    } op_code_t;

    localparam logic [1:0] FUN2_REDEF  = 2'b00;
    localparam logic [1:0] FUN2_LW     = 2'b01;
    localparam logic [1:0] FUN2_SW     = 2'b10;
    localparam logic [1:0] FUN2_BRANCH = 2'b11;

    function automatic logic is_hard_sub(input logic [8:0] instr, input logic [1:0] fun2);
        return (op_code_t'(instr[8:6]) == OP_HARD) && (instr[5:4] == fun2);
    endfunction

endpackage

// File: rtl/roe_wait_timer.sv
// roe_wait_timer: memory wait counter that flags when MAX wait cycles have elapsed
module roe_wait_timer #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt;

    assign expired = (cnt == W'(MAX));

    // clear wins over increment; saturate at MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !expired)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/roe_sequencer.sv
// roe_sequencer: multi-cycle fetch/decode/execute sequencer for the R.O.E 9-bit core
module roe_sequencer
    import roe_sequencer_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [8:0]      imem_data,
    output logic [8:0]      instr_q,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    input  logic            branch_flag,
    output logic            rf_write_en,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            done,
    output logic            err
);

    seq_state_t      state, state_n;
    logic [PC_W-1:0] pc_n;
    logic            load;
    logic            expired;
    logic [3:0]      off;
    logic [PC_W-1:0] off_sext;

    assign off       = instr_q[3:0];
    assign off_sext  = {{(PC_W-4){off[3]}}, off};
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign dmem_req  = (state == MEM);
    assign dmem_we   = (state == MEM) && is_hard_sub(instr_q, FUN2_SW);
    assign rf_write_en = (state == WB);
    assign busy      = (state inside {FETCH, DECODE, EXEC, MEM, WB});
    assign done      = (state == HALT);
    assign err       = (state == ERR);

    roe_wait_timer #(.MAX(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_n != state),
        .inc     ((state == FETCH && !imem_ack) || (state == MEM && !dmem_ack)),
        .expired (expired)
    );

    // next state, next pc and instruction latch enable
    always_comb begin
        state_n = state;
        pc_n    = pc;
        load    = 1'b0;
        case (state)
            IDLE, HALT, ERR: if (start) begin
                state_n = FETCH;
                pc_n    = '0;
            end
            FETCH: if (imem_ack) begin
                load    = 1'b1;
                state_n = DECODE;
            end else if (expired) begin
                state_n = ERR;
            end
            DECODE: state_n = EXEC;
            EXEC: if (is_hard_sub(instr_q, FUN2_LW) || is_hard_sub(instr_q, FUN2_SW)) begin
                state_n = MEM;
            end else if (is_hard_sub(instr_q, FUN2_BRANCH)) begin
                if (off == 4'd0) begin
                    state_n = HALT;
                end else begin
                    state_n = FETCH;
                    pc_n    = branch_flag ? pc + off_sext : pc + PC_W'(1);
                end
            end else begin
                state_n = WB;
            end
            MEM: if (dmem_ack) begin
                if (is_hard_sub(instr_q, FUN2_SW)) begin
                    state_n = FETCH;
                    pc_n    = pc + PC_W'(1);
                end else begin
                    state_n = WB;
                end
            end else if (expired) begin
                state_n = ERR;
            end
            WB: begin
                state_n = FETCH;
                pc_n    = pc + PC_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // program counter and latched instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            instr_q <= '0;
        end else begin
            pc <= pc_n;
            if (load)
                instr_q <= imem_data;
        end
    end

endmodule

// File: tb/tb_roe_sequencer.sv
// tb_roe_sequencer: scoreboard bench for roe_sequencer with directed programs
module tb_roe_sequencer;

    localparam int EV_FETCH = 1;
    localparam int EV_DMEM  = 2;
    localparam int EV_WB    = 3;
    localparam int EV_HALT  = 4;
    localparam int EV_ERR   = 5;

    localparam logic [8:0] I_ADD  = 9'h040;
    localparam logic [8:0] I_LW   = 9'h0D0;
    localparam logic [8:0] I_SW   = 9'h0E0;
    localparam logic [8:0] I_BRE  = 9'h0FE;
    localparam logic [8:0] I_HALT = 9'h0F0;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n, start, imem_ack, dmem_ack, branch_flag;
    logic [8:0] imem_data;
    logic       imem_req, dmem_req, dmem_we, rf_write_en, busy, done, err;
    logic [7:0] imem_addr, pc;
    logic [8:0] instr_q;

    logic [8:0] imem [256];
    ev_t        exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         imem_wait = 0;
    int         dmem_wait = 0;
    int         dreq_cycles = 0;
    int         rf_count = 0;
    logic       prev_done = 1'b0;
    logic       prev_err = 1'b0;

    always #5 clk = ~clk;

    roe_sequencer #(.PC_W(8), .MEM_TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr_q     (instr_q),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .branch_flag (branch_flag),
        .rf_write_en (rf_write_en),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb(input int kind, input int val);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got kind %0d val 0x%0h expected nothing", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                fails++;
                $display("FAIL sb_event: got kind %0d val 0x%0h expected kind %0d val 0x%0h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    function automatic void expect_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endfunction

    task automatic load_prog(input logic [8:0] p0, input logic [8:0] p1, input logic [8:0] p2,
                             input logic [8:0] p3, input logic [8:0] p4);
        for (int i = 0; i < 256; i++) imem[i] = I_HALT;
        imem[0] = p0;
        imem[1] = p1;
        imem[2] = p2;
        imem[3] = p3;
        imem[4] = p4;
        dreq_cycles = 0;
        rf_count = 0;
    endtask

    task automatic start_prog;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int max);
        int n = 0;
        while (!(done || err) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ended"}, 32'(done || err), 32'd1);
        @(negedge clk);
        #1;
        chk({name, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // memory responders: ack after a programmed number of wait cycles
    initial begin
        int icnt = 0;
        int dcnt = 0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        imem_data = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_data = imem[imem_addr];
            if (imem_req) begin
                imem_ack = (icnt == imem_wait);
                icnt++;
            end else begin
                imem_ack = 1'b0;
                icnt = 0;
            end
            if (dmem_req) begin
                dmem_ack = (dcnt == dmem_wait);
                dcnt++;
            end else begin
                dmem_ack = 1'b0;
                dcnt = 0;
            end
        end
    end

    // monitor: turns DUT activity into events and checks them against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (imem_req && imem_ack) sb(EV_FETCH, int'(imem_addr));
            if (dmem_req && dmem_ack) sb(EV_DMEM, int'(dmem_we) * 256 + int'(pc));
            if (rf_write_en) sb(EV_WB, int'(pc));
            if (done && !prev_done) sb(EV_HALT, int'(pc));
            if (err && !prev_err) sb(EV_ERR, int'(pc));
            if (dmem_req) dreq_cycles++;
            if (rf_write_en) rf_count++;
            prev_done = done;
            prev_err = err;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        branch_flag = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = I_HALT;
        #1;
        chk("reset_outs", {imem_req, dmem_req, dmem_we, rf_write_en, busy, done, err, pc, imem_addr, instr_q}, 32'd0);
        #20 rst_n = 1'b1;

        // ADD with zero-wait fetch: write strobe in cycle 4 only
        load_prog(I_ADD, I_HALT, I_HALT, I_HALT, I_HALT);
        expect_ev(EV_FETCH, 0); expect_ev(EV_WB, 0); expect_ev(EV_FETCH, 1); expect_ev(EV_HALT, 1);
        start_prog;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("add_rf_cyc%0d", i + 1), 32'(rf_write_en), 32'(i == 3));
            chk($sformatf("add_req_cyc%0d", i + 1), 32'(imem_req), 32'(i == 0));
        end
        @(negedge clk);
        chk("add_pc", 32'(pc), 32'd1);
        wait_end("add", 50);
        chk("add_halt", {busy, done, err, pc}, {1'b0, 1'b1, 1'b0, 8'd1});
        chk("add_rf_count", 32'(rf_count), 32'd1);

        // asynchronous reset in the middle of a stalled fetch
        imem_wait = 100;
        start_prog;
        @(negedge clk);
        chk("midrst_pre_req", 32'(imem_req), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_outs", {imem_req, dmem_req, dmem_we, rf_write_en, busy, done, err, pc, imem_addr, instr_q}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle", {busy, done, err, pc}, 32'd0);
        imem_wait = 0;

        // three ADDs, LW at pc 3 and SW at pc 4 with two wait cycles each; start while busy ignored
        load_prog(I_ADD, I_ADD, I_ADD, I_LW, I_SW);
        imem[5] = I_HALT;
        dmem_wait = 2;
        for (int i = 0; i < 3; i++) begin
            expect_ev(EV_FETCH, i); expect_ev(EV_WB, i);
        end
        expect_ev(EV_FETCH, 3); expect_ev(EV_DMEM, 3); expect_ev(EV_WB, 3);
        expect_ev(EV_FETCH, 4); expect_ev(EV_DMEM, 256 + 4);
        expect_ev(EV_FETCH, 5); expect_ev(EV_HALT, 5);
        start_prog;
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_end("mem", 200);
        chk("mem_pc", 32'(pc), 32'd5);
        chk("mem_dreq_cycles", 32'(dreq_cycles), 32'd6);
        chk("mem_rf_count", 32'(rf_count), 32'd4);
        dmem_wait = 0;

        // backward branch taken from pc 1 wraps to 0xFF
        load_prog(I_ADD, I_BRE, I_HALT, I_HALT, I_HALT);
        branch_flag = 1'b1;
        expect_ev(EV_FETCH, 0); expect_ev(EV_WB, 0); expect_ev(EV_FETCH, 1);
        expect_ev(EV_FETCH, 255); expect_ev(EV_HALT, 255);
        start_prog;
        wait_end("br_taken", 100);
        chk("br_taken_pc", 32'(pc), 32'hFF);
        chk("br_taken_rf", 32'(rf_count), 32'd1);

        // branch not taken falls through to pc 2
        load_prog(I_ADD, I_BRE, I_HALT, I_HALT, I_HALT);
        branch_flag = 1'b0;
        expect_ev(EV_FETCH, 0); expect_ev(EV_WB, 0); expect_ev(EV_FETCH, 1);
        expect_ev(EV_FETCH, 2); expect_ev(EV_HALT, 2);
        start_prog;
        wait_end("br_nt", 100);
        chk("br_nt_pc", 32'(pc), 32'd2);
        chk("br_nt_rf", 32'(rf_count), 32'd1);
        chk("halt_flags", {busy, done, err}, 32'b010);

        // restart out of HALT goes back to pc 0
        rf_count = 0;
        expect_ev(EV_FETCH, 0); expect_ev(EV_WB, 0); expect_ev(EV_FETCH, 1);
        expect_ev(EV_FETCH, 2); expect_ev(EV_HALT, 2);
        start_prog;
        @(negedge clk);
        chk("restart_fetch", {imem_req, busy, done, pc}, {1'b1, 1'b1, 1'b0, 8'd0});
        wait_end("restart", 100);
        chk("restart_pc", 32'(pc), 32'd2);

        // fetch never acknowledged: ERR after 16 FETCH cycles
        load_prog(I_ADD, I_HALT, I_HALT, I_HALT, I_HALT);
        imem_wait = 100;
        expect_ev(EV_ERR, 0);
        start_prog;
        n = 0;
        for (int i = 0; i < 40 && !err; i++) begin
            @(negedge clk);
            if (imem_req) n++;
        end
        chk("ito_fetch_cycles", 32'(n), 32'd16);
        chk("ito_flags", {busy, done, err, pc}, {1'b0, 1'b0, 1'b1, 8'd0});
        wait_end("ito", 5);

        // ack exactly when the count reaches the limit wins
        imem_wait = 15;
        expect_ev(EV_FETCH, 0); expect_ev(EV_WB, 0); expect_ev(EV_FETCH, 1); expect_ev(EV_HALT, 1);
        start_prog;
        wait_end("ack_at_limit", 200);
        chk("ack_at_limit_flags", {done, err, pc}, {1'b1, 1'b0, 8'd1});
        imem_wait = 0;

        // data access never acknowledged: ERR holds faulting pc
        load_prog(I_ADD, I_LW, I_HALT, I_HALT, I_HALT);
        dmem_wait = 100;
        expect_ev(EV_FETCH, 0); expect_ev(EV_WB, 0); expect_ev(EV_FETCH, 1); expect_ev(EV_ERR, 1);
        start_prog;
        wait_end("dto", 100);
        chk("dto_flags", {done, err, pc}, {1'b0, 1'b1, 8'd1});
        chk("dto_dreq_cycles", 32'(dreq_cycles), 32'd16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
